ring_router_gateway_demux: RTL



---
 rtl/ring_router_gateway_demux.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ring_router_gateway_demux.sv
// Ring ingress demux: steers each worm to the local, ring or external egress.
// Optional packet counters: define RING_ROUTER_GATEWAY_DEMUX_STATS_EN.
package ring_router_gateway_demux_pkg;
   typedef struct packed {
      logic        valid;
      logic        last;
      logic [15:0] data;
   } dii_flit;
endpackage

module ring_router_gateway_demux
   import ring_router_gateway_demux_pkg::*;
#(
   parameter int                     SUBNET_BITS  = 6,
   parameter logic [SUBNET_BITS-1:0] LOCAL_SUBNET = '0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] id,
   input  dii_flit     in_ring,
   output logic        in_ring_ready,
   output dii_flit     out_local,
   input  logic        out_local_ready,
   output dii_flit     out_ring,
   input  logic        out_ring_ready,
   output dii_flit     out_ext,
   input  logic        out_ext_ready
`ifdef RING_ROUTER_GATEWAY_DEMUX_STATS_EN
   ,
   output logic [15:0] stat_local,
   output logic [15:0] stat_ring,
   output logic [15:0] stat_ext
`endif
);

   typedef enum logic [1:0] {
      IDLE, WORM_LOCAL, WORM_RING, WORM_EXT
   } state_t;

   typedef enum logic [1:0] {
      R_LOCAL, R_RING, R_EXT
   } route_t;

   state_t      state;
   state_t      state_nxt;
   route_t      in_route;
   route_t      slot_route;
   logic        slot_valid;
   logic        slot_last;
   logic [15:0] slot_data;
   logic        sel_ready;
   logic        xfer;

   assign xfer = in_ring.valid & in_ring_ready;
   assign in_ring_ready = ~slot_valid | sel_ready;

   // Route of the incoming flit: decoded on a header, else the locked worm route
   always_comb begin
      in_route = R_EXT;
      unique case (state)
         WORM_LOCAL: in_route = R_LOCAL;
         WORM_RING:  in_route = R_RING;
         WORM_EXT:   in_route = R_EXT;
         default: begin
            if (in_ring.data == id)
               in_route = R_LOCAL;
            else if (in_ring.data[15 -: SUBNET_BITS] == LOCAL_SUBNET)
               in_route = R_RING;
            else
               in_route = R_EXT;
         end
      endcase
   end

   // Ready of the egress the held flit is headed for
   always_comb begin
      sel_ready = 1'b0;
      unique case (1'b1)
         (slot_route == R_LOCAL): sel_ready = out_local_ready;
         (slot_route == R_RING):  sel_ready = out_ring_ready;
         default:                 sel_ready = out_ext_ready;
      endcase
   end

   // Worm tracking: lock on a non-tail header, release on the tail
   always_comb begin
      state_nxt = state;
      if (xfer) begin
         if (in_ring.last)
            state_nxt = IDLE;
         else begin
            unique case (in_route)
               R_LOCAL: state_nxt = WORM_LOCAL;
               R_RING:  state_nxt = WORM_RING;
               default: state_nxt = WORM_EXT;
            endcase
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Output slot: refills (or empties) whenever the upstream may advance
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_valid <= 1'b0;
         slot_last  <= 1'b0;
         slot_data  <= '0;
         slot_route <= R_LOCAL;
      end else if (in_ring_ready) begin
         slot_valid <= in_ring.valid;
         if (in_ring.valid) begin
            slot_last  <= in_ring.last;
            slot_data  <= in_ring.data;
            slot_route <= in_route;
         end
      end
   end

   assign out_local = '{valid: slot_valid & (slot_route == R_LOCAL),
                        last: slot_last, data: slot_data};
   assign out_ring  = '{valid: slot_valid & (slot_route == R_RING),
                        last: slot_last, data: slot_data};
   assign out_ext   = '{valid: slot_valid & (slot_route == R_EXT),
                        last: slot_last, data: slot_data};

`ifdef RING_ROUTER_GATEWAY_DEMUX_STATS_EN
   logic tail_out;
   assign tail_out = slot_valid & sel_ready & slot_last;

   // Saturating packet counters, bumped as a tail leaves the slot
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_local <= '0;
         stat_ring  <= '0;
         stat_ext   <= '0;
      end else if (tail_out) begin
         unique case (slot_route)
            R_LOCAL: if (stat_local != 16'hFFFF) stat_local <= stat_local + 16'd1;
            R_RING:  if (stat_ring  != 16'hFFFF) stat_ring  <= stat_ring  + 16'd1;
            default: if (stat_ext   != 16'hFFFF) stat_ext   <= stat_ext   + 16'd1;
         endcase
      end
   end
`endif

endmodule
